// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the r200 5-stage pipeline; optional perf counters under R200_PERF_CNT_EN.
// Latency: zero-cycle, all controls are combinational from registered state plus current inputs.
// Backpressure: a dmem wait freezes every stage; load-use stalls hold PC and IF/ID and bubble ID/EX.
module pipe_ctrl #(
  parameter int LU_STALLS   = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CW          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwr,
  input  logic [1:0] ex_wbsel,
  input  logic       ex_willbr,
  input  logic       ex_willjmp,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       pc_redirect,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_en,
  output logic       id_ex_flush,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       mem_err
`ifdef R200_PERF_CNT_EN
  ,
  output logic [CW-1:0] perf_lu_stall,
  output logic [CW-1:0] perf_flush,
  output logic [CW-1:0] perf_mem_stall
`endif
);

  typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT} state_t;

  localparam logic [CW-1:0] TMO     = CW'(MEM_TIMEOUT);
  localparam logic [1:0]    LU_INIT = 2'(LU_STALLS - 1);

  state_t        state, state_nxt, ret_state, ret_nxt, eval_st;
  logic [1:0]    lu_cnt, lu_nxt;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic          mem_err_q, mem_err_nxt;
  logic          lu_haz, redir, mwait;
  logic          freeze, stall, redir_acc;

  assign lu_haz = ex_regwr && (ex_wbsel == 2'b01) && (ex_rd != 5'd0) &&
                  ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign redir  = ex_willbr | ex_willjmp;
  assign mwait  = mem_req & ~mem_ready;

  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    lu_nxt    = lu_cnt;
    wait_nxt  = wait_cnt;
    eval_st   = state;
    freeze    = 1'b0;
    stall     = 1'b0;
    redir_acc = 1'b0;

    // A completing wait is handled as an ordinary cycle of the interrupted state.
    if (state == MEMWAIT) begin
      if (!mem_ready) begin
        freeze   = 1'b1;
        wait_nxt = (wait_cnt == TMO) ? wait_cnt : wait_cnt + 1'b1;
      end else begin
        eval_st  = ret_state;
        wait_nxt = '0;
      end
    end

    if (!freeze) begin
      if (mwait) begin
        freeze    = 1'b1;
        ret_nxt   = (eval_st == LDSTALL) ? LDSTALL : RUN;
        wait_nxt  = CW'(1);
        state_nxt = MEMWAIT;
      end else if (eval_st == LDSTALL) begin
        stall = 1'b1;
        if (lu_cnt <= 2'd1) begin
          lu_nxt    = 2'd0;
          state_nxt = RUN;
        end else begin
          lu_nxt    = lu_cnt - 2'd1;
          state_nxt = LDSTALL;
        end
      end else if (redir) begin
        redir_acc = 1'b1;
        state_nxt = RUN;
      end else if (lu_haz) begin
        stall = 1'b1;
        if (LU_STALLS > 1) begin
          lu_nxt    = LU_INIT;
          state_nxt = LDSTALL;
        end else begin
          state_nxt = RUN;
        end
      end else begin
        state_nxt = RUN;
      end
    end

    mem_err_nxt = mem_err_q | ((state_nxt == MEMWAIT) && (wait_nxt == TMO));

    pc_en       = 1'b1;
    pc_redirect = 1'b0;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_en    = 1'b0;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
    end else if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (redir_acc) begin
      pc_redirect = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  assign mem_err = mem_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      ret_state <= RUN;
      lu_cnt    <= 2'd0;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      lu_cnt    <= lu_nxt;
      wait_cnt  <= wait_nxt;
      mem_err_q <= mem_err_nxt;
    end
  end

`ifdef R200_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_stall  <= '0;
      perf_flush     <= '0;
      perf_mem_stall <= '0;
    end else begin
      if (stall && (perf_lu_stall != '1))      perf_lu_stall  <= perf_lu_stall + 1'b1;
      if (redir_acc && (perf_flush != '1))     perf_flush     <= perf_flush + 1'b1;
      if (mwait && (perf_mem_stall != '1))     perf_mem_stall <= perf_mem_stall + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the r200 5-stage pipeline (IF/ID/EX/MEM/WB). It decides each cycle which pipeline registers advance, which are bubbled, and when the PC is redirected. It replaces the scattered stall logic with one FSM that handles three cases:
- load-use interlocks
- EX-resolved branch/jump redirects
- multi-cycle data-memory waits, with a watchdog timeout

Parameters:
LU_STALLS, 1, bubbles inserted per load-use hazard (1..3); 1 = full MEM forwarding.
MEM_TIMEOUT, 255, MEMWAIT cycles before mem_err is set (1..65535).
CW, 16, width of internal wait counter and optional perf counters.

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
id_rs1  in  5  ID-stage source register 1
id_rs2  in  5  ID-stage source register 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  EX-stage destination register
ex_regwr  in  1  EX instruction writes a register
ex_wbsel  in  2  EX writeback source; 2'b01 = dmem (load)
ex_willbr  in  1  EX branch taken
ex_willjmp  in  1  EX jump (jal/jalr)
mem_req  in  1  MEM stage accessing dmem this cycle
mem_ready  in  1  dmem access completes this cycle
pc_en  out  1  PC register update enable
pc_redirect  out  1  select EX branch/jump target into PC
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_en  out  1  ID/EX register enable
id_ex_flush  out  1  ID/EX loads bubble (regwr=0, memwr=0)
ex_mem_en  out  1  EX/MEM register enable
mem_wb_en  out  1  MEM/WB register enable
mem_err  out  1  sticky dmem timeout flag

Behaviour:
- Registered state: `state` ∈ {RUN, LDSTALL, MEMWAIT}, `ret_state`, `lu_cnt` (2b), `wait_cnt` (CW), `mem_err`.
- All outputs are combinational from the registered state plus the current inputs, so there is zero-cycle response.
- Reset (async, rst=1):
  - state=RUN, counters=0, mem_err=0.
  - While rst=1, all `*_en`=0, both flushes=1, pc_redirect=0.
- Hazard definitions:
  - `lu_haz` = ex_regwr & ex_wbsel==2'b01 & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - `redir` = ex_willbr | ex_willjmp.
  - `mwait` = mem_req & ~mem_ready.
- Event priority within one cycle: mwait > redir > lu_haz.
- Default (no event): all en=1, flushes=0, pc_redirect=0.
- RUN state:
  - mwait: all en=0, flushes=0. ret_state=RUN, wait_cnt=1, go MEMWAIT.
  - redir: pc_redirect=1, if_id_flush=1, id_ex_flush=1, all en=1. Stay RUN. Any lu_haz this cycle is ignored because the ID instruction is killed.
  - lu_haz: pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en=mem_wb_en=1.
    - If LU_STALLS>1: lu_cnt=LU_STALLS-1, go LDSTALL.
    - Otherwise stay RUN.
- LDSTALL state:
  - Outputs identical to the lu_haz case.
  - Each non-mwait cycle: lu_cnt decrements; when lu_cnt reaches 1 → RUN on the next edge.
  - mwait here: freeze all, ret_state=LDSTALL, lu_cnt held, go MEMWAIT.
  - redir cannot occur (EX holds a bubble); if it is asserted anyway it is ignored.
- MEMWAIT state:
  - While mem_ready=0: all en=0, flushes=0, wait_cnt increments and saturates at MEM_TIMEOUT.
  - wait_cnt==MEM_TIMEOUT sets mem_err=1, which stays set until rst. The FSM keeps waiting.
  - On mem_ready=1: the cycle's outputs are evaluated as if in ret_state, including redir/lu_haz. Next state = the state that evaluation produces; wait_cnt is cleared.
- x0 never creates a hazard.
- A redirect never coincides with a freeze: mwait masks redir, and EX holds until the freeze releases.

Optional Feature:
R200_PERF_CNT_EN:
- When defined, adds three outputs, each CW-wide, saturating, reset to 0:
  - `perf_lu_stall`: counts each cycle with lu_haz or in LDSTALL.
  - `perf_flush`: counts each cycle with redir accepted.
  - `perf_mem_stall`: counts each cycle with mwait.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Load-use, LU_STALLS=1: ex_wbsel=01, ex_regwr=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all en=1.
2. Load-use, LU_STALLS=3, same stimulus → exactly 3 consecutive stall cycles, then RUN. Repeat with ex_rd=0 → no stall.
3. Branch plus simultaneous load-use: ex_willbr=1 with lu_haz=1 → pc_redirect=1, if_id_flush=id_ex_flush=1, pc_en=1, no LDSTALL entry.
4. Mem wait: mem_req=1, mem_ready=0 for 4 cycles, then 1 → all en=0 for 4 cycles, all en=1 on the ready cycle, mem_err=0.
5. Timeout, MEM_TIMEOUT=8: hold mem_ready=0 for 10 cycles → mem_err rises on the 8th MEMWAIT cycle and stays 1. Assert rst mid-wait → immediate RUN, mem_err=0.
6. Mem wait inside LDSTALL, LU_STALLS=3: mwait on the 2nd stall cycle for 2 cycles → freeze 2 cycles, then the remaining stall count resumes, for 3 stall cycles total excluding the freeze.
